// File: rtl/permuter_arbiter.sv
// permuter_arbiter
//   Registered 2x2 arbitration stage for the bufferless permutation network.
//   Two flits arrive per cycle. The older flit wins: the one with the larger
//   priority, or the round-robin pointer's choice on equal priority. The
//   winner is steered onto its preferred output lane and the loser takes the
//   other lane. The permuted pair, their valid bits and the swap decision are
//   registered, so the stage has one cycle of latency and no combinational
//   path from input to output.
//
// Parameters
//   WIDTH     flit width in bits (default `WIDTH_INTERNAL_PV)
//   PRIO_LSB  LSB of the unsigned priority field inside a flit
//   PRIO_W    priority field width
//   PREF_BIT  flit bit naming the preferred output (0 -> out_flit0, 1 -> out_flit1)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   en           stage advance; when low, every register holds
//   in_flit0/1   input flits, lanes 0 and 1
//   in_valid0/1  input valid bits
//   out_flit0/1  registered permuted flits
//   out_valid0/1 registered valid bits, travelling with their flits
//   swap_q       registered swap decision for the current outputs
//   stats_clr    synchronous clear of the deflection counter (works regardless of en)
//   deflect_cnt  saturating 16-bit deflection count
//
// Configuration
//   PERMUTER_STATS_EN  when defined, the deflection counter is built. When it
//                      is undefined, deflect_cnt is tied to zero and stats_clr
//                      is ignored. Arbitration and datapath are identical in
//                      both builds.

`ifndef WIDTH_INTERNAL_PV
`define WIDTH_INTERNAL_PV 32
`endif

module permuter_arbiter #(
  parameter int WIDTH    = `WIDTH_INTERNAL_PV,
  parameter int PRIO_LSB = 0,
  parameter int PRIO_W   = 8,
  parameter int PREF_BIT = WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_flit0,
  input  logic [WIDTH-1:0] in_flit1,
  input  logic             in_valid0,
  input  logic             in_valid1,
  output logic [WIDTH-1:0] out_flit0,
  output logic [WIDTH-1:0] out_flit1,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic             swap_q,
  input  logic             stats_clr,
  output logic [15:0]      deflect_cnt
);

  logic [PRIO_W-1:0] w_prio0;
  logic [PRIO_W-1:0] w_prio1;
  logic              w_pref0;
  logic              w_pref1;
  logic              w_bothValid;
  logic              w_eqPrio;
  logic              w_winner;
  logic              w_swap;
  logic              w_deflect;

  logic [WIDTH-1:0]  r_outFlit0;
  logic [WIDTH-1:0]  r_outFlit1;
  logic              r_outValid0;
  logic              r_outValid1;
  logic              r_swap;
  logic              r_rrPtr;

  assign w_prio0     = in_flit0[PRIO_LSB +: PRIO_W];
  assign w_prio1     = in_flit1[PRIO_LSB +: PRIO_W];
  assign w_pref0     = in_flit0[PREF_BIT];
  assign w_pref1     = in_flit1[PREF_BIT];
  assign w_bothValid = in_valid0 & in_valid1;
  assign w_eqPrio    = (w_prio0 == w_prio1);

  // A deflection means both flits want the same lane, so the loser is pushed
  // onto the lane it did not ask for.
  assign w_deflect   = w_bothValid & (w_pref0 == w_pref1);

  // Winner selection. With no valid flit the swap is forced to 0, so idle
  // cycles pass the lanes straight through.
  always_comb begin
    w_winner = 1'b0;
    w_swap   = 1'b0;
    if (w_bothValid) begin
      if (w_prio0 > w_prio1) begin
        w_winner = 1'b0;
      end else if (w_prio1 > w_prio0) begin
        w_winner = 1'b1;
      end else begin
        w_winner = r_rrPtr;
      end
    end else if (in_valid1) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
    // Swapping is needed exactly when the winner's preferred lane differs
    // from the lane it arrived on.
    if (in_valid0 | in_valid1) begin
      w_swap = (w_winner ? w_pref1 : w_pref0) ^ w_winner;
    end
  end

  // Output register stage. Invalid flits are permuted like valid ones and are
  // not zeroed, so the valid bits alone qualify the data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outFlit0  <= '0;
      r_outFlit1  <= '0;
      r_outValid0 <= 1'b0;
      r_outValid1 <= 1'b0;
      r_swap      <= 1'b0;
    end else if (en) begin
      r_outFlit0  <= w_swap ? in_flit1  : in_flit0;
      r_outFlit1  <= w_swap ? in_flit0  : in_flit1;
      r_outValid0 <= w_swap ? in_valid1 : in_valid0;
      r_outValid1 <= w_swap ? in_valid0 : in_valid1;
      r_swap      <= w_swap;
    end
  end

  // Round-robin tie-break pointer. It moves only when it was actually
  // consulted, so unequal-priority traffic does not disturb fairness.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rrPtr <= 1'b0;
    end else if (en && w_bothValid && w_eqPrio) begin
      r_rrPtr <= ~r_rrPtr;
    end
  end

  assign out_flit0  = r_outFlit0;
  assign out_flit1  = r_outFlit1;
  assign out_valid0 = r_outValid0;
  assign out_valid1 = r_outValid1;
  assign swap_q     = r_swap;

`ifdef PERMUTER_STATS_EN
  logic [15:0] r_deflectCnt;

  // Saturating deflection counter. The clear is taken even while the stage is
  // stalled and takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deflectCnt <= 16'h0000;
    end else if (stats_clr) begin
      r_deflectCnt <= 16'h0000;
    end else if (en && w_deflect && (r_deflectCnt != 16'hFFFF)) begin
      r_deflectCnt <= r_deflectCnt + 16'd1;
    end
  end

  assign deflect_cnt = r_deflectCnt;
`else
  logic w_unused_stats;

  assign w_unused_stats = stats_clr ^ w_deflect;
  assign deflect_cnt    = 16'h0000;
`endif

endmodule

// File: doc/permuter_arbiter.md
# permuter_arbiter

Registered 2x2 arbitration stage for the bufferless permutation network: it accepts two flits per cycle, chooses a winner by priority with a round-robin tie-break, generates the swap control for the winner's preferred output, and drives the permuted flits out one cycle later. It is the controlling counterpart of the combinational swap element. The swap element consumes a swap bit; this block produces it and registers the result. Instances are chained to form the multi-stage permutation network between the router input latches and the output ports.

## Interface
- WIDTH, default `WIDTH_INTERNAL_PV: flit width in bits.
- PRIO_LSB, default 0: LSB of the priority field inside a flit.
- PRIO_W, default 8: priority field width. The field is unsigned, and a larger value is older and wins.
- PREF_BIT, default WIDTH-1: flit bit giving the preferred output (0 selects out_flit0, 1 selects out_flit1).
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- en, input, 1: stage advance. When it is 0, all registers hold.
- in_flit0, input, WIDTH: flit on lane 0.
- in_flit1, input, WIDTH: flit on lane 1.
- in_valid0, input, 1: in_flit0 is valid.
- in_valid1, input, 1: in_flit1 is valid.
- out_flit0, output, WIDTH: registered permuted flit, lane 0.
- out_flit1, output, WIDTH: registered permuted flit, lane 1.
- out_valid0, output, 1: out_flit0 is valid.
- out_valid1, output, 1: out_flit1 is valid.
- swap_q, output, 1: registered swap decision that applies to the current outputs.
- stats_clr, input, 1: synchronous clear of the deflection counter.
- deflect_cnt, output, 16: deflection count. It is only live with the configuration macro.

## Operation
- The winner is chosen combinationally from the sampled inputs:
  - Only lane 0 valid: winner is 0.
  - Only lane 1 valid: winner is 1.
  - Neither valid: winner is 0 and swap is 0.
  - Both valid: the strictly larger priority wins. On equal priority the winner is rr_ptr.
- swap is the winner's PREF_BIT XOR the winner index. The winning flit always lands on its preferred lane.
- The loser takes the other lane.
  - A deflection occurs when both lanes are valid and both flits have the same PREF_BIT.
- Valid bits move with their flits: out_valid0 = swap ? in_valid1 : in_valid0, and out_valid1 is the mirror.
- Invalid-flit data passes through unchanged and is not zeroed.
- rr_ptr is a 1-bit state register:
  - It toggles only on a cycle with en=1, both lanes valid and equal priority.
  - It is otherwise held.
- No backpressure exists. Every valid input flit appears on exactly one output one cycle later. Flits are never dropped or duplicated.

## Timing
- Latency is 1 cycle: inputs sampled on edge N appear on the outputs after edge N.
- en=0 on an edge: outputs, swap_q, rr_ptr and the counter all hold. Inputs for that cycle are ignored, and upstream owns stall alignment.
- Reset (reset_n=0) takes effect immediately, independent of clk. Reset values:
  - out_flit0 and out_flit1: 0.
  - out_valid0 and out_valid1: 0.
  - swap_q: 0.
  - rr_ptr: 0.
  - deflect_cnt: 0.
- A reset asserted mid-stream discards the flit in flight.
- The first sample after reset release is taken on the first rising edge with reset_n=1 and en=1.
- stats_clr is sampled on the clock and works regardless of en. If it coincides with an increment, the clear wins and the counter reads 0.
- The outputs are direct register outputs. There is no combinational path from input to output.

## Configuration
- `PERMUTER_STATS_EN` defined:
  - deflect_cnt increments by 1 on each en=1 edge that has a deflection.
  - It saturates at 16'hFFFF and does not wrap.
- Not defined:
  - The counter register is not built and deflect_cnt is tied to 16'h0000.
  - stats_clr is ignored.
  - The datapath and arbitration behaviour are identical either way.

## Test plan
- Both valid, flit0 priority 8'h10 with PREF 1, flit1 priority 8'h05 with PREF 1: one cycle later swap_q=1, out_flit1=flit0, out_flit0=flit1, both valid, and deflect_cnt reaches 1 (macro on).
- Only in_valid1, PREF 1: swap_q=0, out_flit1=in_flit1, out_valid1=1, out_valid0=0, and no counter change.
- Equal priority 8'h20 on both lanes with PREF 0, presented four cycles in a row from reset: winners alternate 0,1,0,1, swap_q toggles 0,1,0,1, and rr_ptr is back to 0 afterwards.
- Hold en=0 for 3 cycles while changing the inputs: outputs, swap_q and deflect_cnt stay frozen, and the next en=1 edge captures the current inputs.
- Force 65537 deflections, then assert stats_clr together with one more deflection: deflect_cnt reads 16'hFFFF before the clear and 0 after it. With the macro off it reads 0 throughout.
- Assert reset_n=0 between clock edges with valid outputs present: all outputs go to 0 immediately, before the next edge, and rr_ptr resets to 0.
